// File: rtl/sim_dmem_checker.sv
// Self-checking data memory for CPU benches: byte-enable storage, result checks,
// end-marker/timeout completion. Define SIM_DMEM_TRACE_EN for store/check/summary tracing.
module sim_dmem_checker #(
  parameter int unsigned              DEPTH_WORDS    = 1024,
  parameter int unsigned              NUM_CHECKS     = 1,
  parameter logic [NUM_CHECKS*32-1:0] CHECK_ADDRS    = {32'h200},
  parameter logic [NUM_CHECKS*32-1:0] CHECK_VALS     = {32'h5},
  parameter logic [31:0]              END_ADDR       = 32'h300,
  parameter int unsigned              DRAIN_CYCLES   = 5,
  parameter int unsigned              TIMEOUT_CYCLES = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           d_mem_addr,
  input  logic [31:0]           d_mem_wdata,
  input  logic [3:0]            d_mem_wen,
  output logic [31:0]           d_mem_rdata,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic                  oob_err,
  output logic [NUM_CHECKS-1:0] checks_seen,
  output logic [NUM_CHECKS-1:0] checks_fail,
  output logic [31:0]           cycle_count
);

  localparam int unsigned AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [63:0] BYTE_LIMIT = 64'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e                  state;
  logic [7:0]              drain_cnt;
  logic [31:0]             mem [DEPTH_WORDS];
  logic                    store, in_range, store_ok, end_hit;
  logic [AW-1:0]           idx;
  logic [31:0]             old_word, merged, cycle_inc;
  logic [NUM_CHECKS-1:0]   seen_d, fail_d;
  logic                    pass_d;

  assign store       = |d_mem_wen;
  assign in_range    = {32'h0, d_mem_addr} < BYTE_LIMIT;
  assign store_ok    = store & in_range;
  assign idx         = d_mem_addr[AW+1:2];
  assign old_word    = in_range ? mem[idx] : 32'h0;
  assign d_mem_rdata = old_word;
  // End marker matches on word address regardless of the storage range.
  assign end_hit     = store & (d_mem_addr[31:2] == END_ADDR[31:2]);
  assign cycle_inc   = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : cycle_count + 32'd1;

  always_comb begin
    merged = old_word;
    for (int k = 0; k < 4; k++) begin
      if (d_mem_wen[k]) merged[8*k +: 8] = d_mem_wdata[8*k +: 8];
    end
  end

  always_comb begin
    seen_d = checks_seen;
    fail_d = checks_fail;
    if (store_ok && state != StDone) begin
      for (int i = 0; i < NUM_CHECKS; i++) begin
        if (d_mem_addr[31:2] == CHECK_ADDRS[32*i+2 +: 30]) begin
          seen_d[i] = 1'b1;
          fail_d[i] = (merged != CHECK_VALS[32*i +: 32]);
        end
      end
    end
    pass_d = (&seen_d) & ~(|fail_d);
  end

  // Storage is deliberately never reset so a bench can inspect it after a reset.
  always_ff @(posedge clk) begin
    if (rst_n && store_ok) begin
      for (int k = 0; k < 4; k++) begin
        if (d_mem_wen[k]) mem[idx][8*k +: 8] <= d_mem_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= StRun;
      drain_cnt   <= 8'd0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      oob_err     <= 1'b0;
      checks_seen <= '0;
      checks_fail <= '0;
      cycle_count <= 32'd0;
    end else begin
      if (store && !in_range) oob_err <= 1'b1;
      checks_seen <= seen_d;
      checks_fail <= fail_d;
      unique case (state)
        StRun: begin
          if (end_hit) begin
            cycle_count <= cycle_inc;
            if (DRAIN_CYCLES == 0) begin
              state <= StDone;
              done  <= 1'b1;
              pass  <= pass_d;
            end else begin
              state     <= StDrain;
              drain_cnt <= 8'(DRAIN_CYCLES);
            end
          end else if (cycle_count == TIMEOUT_CYCLES) begin
            state   <= StDone;
            done    <= 1'b1;
            timeout <= 1'b1;
            pass    <= 1'b0;
          end else begin
            cycle_count <= cycle_inc;
          end
        end
        StDrain: begin
          cycle_count <= cycle_inc;
          if (drain_cnt == 8'd1) begin
            state <= StDone;
            done  <= 1'b1;
            pass  <= pass_d;
          end else begin
            drain_cnt <= drain_cnt - 8'd1;
          end
        end
        StDone: ;
        default: state <= StRun;
      endcase
    end
  end

`ifdef SIM_DMEM_TRACE_EN
  logic trace_done;

  always_ff @(posedge clk) begin
    trace_done <= done;
    if (rst_n) begin
      if (store_ok) begin
        $display("[dmem] cyc=%0d store addr=%h wen=%b data=%h", cycle_count, d_mem_addr,
                 d_mem_wen, merged);
        if (state != StDone) begin
          for (int i = 0; i < NUM_CHECKS; i++) begin
            if (d_mem_addr[31:2] == CHECK_ADDRS[32*i+2 +: 30]) begin
              $display("[dmem] check %0d expected=%h actual=%h", i, CHECK_VALS[32*i +: 32],
                       merged);
            end
          end
        end
      end
      if (store && !in_range) $display("[dmem] cyc=%0d out-of-range store addr=%h",
                                       cycle_count, d_mem_addr);
      if (done && !trace_done) begin
        $display("[dmem] result %s cycles=%0d",
                 timeout ? "TIMEOUT" : (pass ? "PASS" : "FAIL"), cycle_count);
      end
    end
  end
`else
  // Tracing disabled: status ports only.
`endif

endmodule

// File: tb/tb_sim_dmem_checker.sv
// Bench for sim_dmem_checker: directed completion scenarios plus random stores
// scored against an array model of the storage and the 0x200 result check.
module tb_sim_dmem_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, wdata;
  logic [3:0]  wen;

  logic [31:0] a_rdata, a_count, b_rdata, b_count;
  logic        a_done, a_pass, a_timeout, a_oob;
  logic        b_done, b_pass, b_timeout, b_oob;
  logic [0:0]  a_seen, a_fail;
  logic [1:0]  b_seen, b_fail;

  int total = 0;
  int bad   = 0;

  // Reference state: storage words plus the single default check (0x200 == 5).
  logic [31:0] mdl [0:1023];
  bit          m_seen, m_fail, m_oob;

  always #5 clk = ~clk;

  sim_dmem_checker dut_a (
    .clk(clk), .rst_n(rst_n), .d_mem_addr(addr), .d_mem_wdata(wdata), .d_mem_wen(wen),
    .d_mem_rdata(a_rdata), .done(a_done), .pass(a_pass), .timeout(a_timeout),
    .oob_err(a_oob), .checks_seen(a_seen), .checks_fail(a_fail), .cycle_count(a_count)
  );

  sim_dmem_checker #(
    .NUM_CHECKS(2), .CHECK_ADDRS({32'h204, 32'h200}), .CHECK_VALS({32'h9, 32'h5}),
    .DRAIN_CYCLES(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .d_mem_addr(addr), .d_mem_wdata(wdata), .d_mem_wen(wen),
    .d_mem_rdata(b_rdata), .done(b_done), .pass(b_pass), .timeout(b_timeout),
    .oob_err(b_oob), .checks_seen(b_seen), .checks_fail(b_fail), .cycle_count(b_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    wen = 4'h0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    wen   = 4'h0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_seen = 0; m_fail = 0; m_oob = 0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    logic [31:0] word;
    addr = a; wdata = d; wen = w;
    if (w != 4'h0) begin
      if (a < 32'h1000) begin
        word = mdl[a[11:2]];
        for (int k = 0; k < 4; k++) if (w[k]) word[8*k +: 8] = d[8*k +: 8];
        mdl[a[11:2]] = word;
        if (a[31:2] == 30'h80) begin
          m_seen = 1;
          m_fail = (word != 32'h5);
        end
      end else begin
        m_oob = 1;
      end
    end
    tick();
    wen = 4'h0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a; wen = 4'h0;
    #1;
    chk(tag, a_rdata, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d, ra;
    logic [3:0]  w;
    int          sel;

    rst_n = 1'b0; addr = 32'h0; wdata = 32'h0; wen = 4'h0;
    tick(); tick();
    chk("rst_done", a_done, 0);
    chk("rst_pass", a_pass, 0);
    chk("rst_timeout", a_timeout, 0);
    chk("rst_oob", a_oob, 0);
    chk("rst_seen", a_seen, 0);
    chk("rst_fail", a_fail, 0);
    chk("rst_count", a_count, 0);
    rst_n = 1'b1;

    // Matching result, marker at cycle 10, five-cycle drain.
    do_reset();
    store(32'h200, 32'h5, 4'hF);
    rd("rd_after_store", 32'h200, 32'h5);
    idle(9);
    chk("count_before_marker", a_count, 10);
    store(32'h300, 32'h0, 4'hF);
    chk("b_drain0_done", b_done, 1);
    chk("b_drain0_count", b_count, 11);
    chk("a_drain_not_done", a_done, 0);
    idle(4);
    chk("done_early", a_done, 0);
    idle(1);
    chk("t1_done", a_done, 1);
    chk("t1_pass", a_pass, 1);
    chk("t1_seen", a_seen, 1);
    chk("t1_fail", a_fail, 0);
    chk("t1_count", a_count, 16);
    idle(3);
    chk("t1_count_hold", a_count, 16);

    // Mismatching result.
    do_reset();
    store(32'h200, 32'h7, 4'hF);
    store(32'h300, 32'h0, 4'hF);
    idle(5);
    chk("t2_done", a_done, 1);
    chk("t2_fail", a_fail, 1);
    chk("t2_pass", a_pass, 0);
    chk("t2_timeout", a_timeout, 0);

    // Byte-lane merge.
    do_reset();
    store(32'h200, 32'h0000_00FF, 4'hF);
    store(32'h200, 32'h0000_0005, 4'h1);
    rd("t3_merged", 32'h200, 32'h5);
    store(32'h300, 32'h0, 4'hF);
    idle(5);
    chk("t3_fail", a_fail, 0);
    chk("t3_pass", a_pass, 1);

    // Timeout, then a store accepted while DONE.
    do_reset();
    idle(100);
    chk("t4_pre_done", a_done, 0);
    chk("t4_pre_count", a_count, 100);
    idle(1);
    chk("t4_done", a_done, 1);
    chk("t4_timeout", a_timeout, 1);
    chk("t4_pass", a_pass, 0);
    chk("t4_count", a_count, 100);
    idle(2);
    chk("t4_count_hold", a_count, 100);
    store(32'h204, 32'h0000_ABCD, 4'hF);
    rd("t4_done_write", 32'h204, 32'h0000_ABCD);

    // Marker on the edge where the timeout would fire.
    do_reset();
    idle(100);
    store(32'h300, 32'h0, 4'hF);
    chk("t4b_b_done", b_done, 1);
    chk("t4b_b_timeout", b_timeout, 0);
    idle(5);
    chk("t4b_done", a_done, 1);
    chk("t4b_timeout", a_timeout, 0);
    chk("t4b_count", a_count, 106);

    // Out-of-range store.
    do_reset();
    store(32'h0, 32'h1122_3344, 4'hF);
    rd("t5_rd_oob_pre", 32'h1000, 32'h0);
    chk("t5_oob_pre", a_oob, 0);
    store(32'h1000, 32'hDEAD_BEEF, 4'hF);
    chk("t5_oob", a_oob, 1);
    rd("t5_rd_oob", 32'h1000, 32'h0);
    rd("t5_mem_unchanged", 32'h0, 32'h1122_3344);

    // Fill a working region with known data, then random stores against the model.
    do_reset();
    for (int i = 0; i < 64; i++) store(32'(i) << 2, $urandom, 4'hF);
    store(32'h200, $urandom, 4'hF);
    do_reset();
    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 3) a = 32'h200;
      else if (sel == 9) a = 32'h1000 + ($urandom_range(0, 255) << 2);
      else a = $urandom_range(0, 63) << 2;
      w = 4'($urandom_range(0, 15));
      d = (sel < 2) ? 32'h5 : $urandom;
      store(a, d, w);
      ra = ($urandom_range(0, 4) == 0) ? 32'h200 : ($urandom_range(0, 63) << 2);
      rd("rand_rd", ra, mdl[ra[11:2]]);
    end
    chk("rand_count", a_count, 60);
    chk("rand_seen", a_seen, 32'(m_seen));
    chk("rand_fail", a_fail, 32'(m_fail));
    chk("rand_oob", a_oob, 32'(m_oob));
    store(32'h300, 32'h0, 4'hF);
    idle(5);
    chk("rand_done", a_done, 1);
    chk("rand_pass", a_pass, 32'(m_seen && !m_fail));

    // Two checks, only one stored; then a one-cycle reset pulse.
    do_reset();
    store(32'h200, 32'h5, 4'hF);
    store(32'h300, 32'h0, 4'hF);
    chk("t6_b_done", b_done, 1);
    chk("t6_b_seen", b_seen, 32'h1);
    chk("t6_b_pass", b_pass, 0);
    idle(5);
    chk("t6_a_pass", a_pass, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_rst_b_done", b_done, 0);
    chk("t6_rst_b_seen", b_seen, 0);
    chk("t6_rst_b_count", b_count, 0);
    chk("t6_rst_a_done", a_done, 0);
    chk("t6_rst_a_pass", a_pass, 0);
    chk("t6_rst_a_seen", a_seen, 0);
    chk("t6_rst_a_count", a_count, 0);
    rd("t6_mem_kept", 32'h200, 32'h5);
    chk("t6_b_mem_kept", b_rdata, 32'h5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
